// File: rtl/cpu_debug_scan_pkg.sv
// Shared types and constants for the Nios II debug scan master.
// IR codes select the debug slave's scan-chain target.
package cpu_debug_scan_pkg;

    localparam int DEF_SR_WIDTH = 38;
    localparam int DEF_IR_WIDTH = 2;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_RSP
    } scan_state_t;

endpackage

// File: rtl/cpu_debug_tck_gen.sv
// Scan clock divider: tck low then high for TCK_DIV clk cycles each,
// with strobes marking the rising edge and the last cycle of a period.
module cpu_debug_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tck,
    output logic tck_rise,
    output logic period_end
);

    localparam int P  = 2 * TCK_DIV;
    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] RISE_AT = CW'(TCK_DIV - 1);
    localparam logic [CW-1:0] END_AT  = CW'(P - 1);

    logic [CW-1:0] cnt;

    // Strobes are valid for the cycle before the edge they describe.
    assign tck_rise   = en & (cnt == RISE_AT);
    assign period_end = en & (cnt == END_AT);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= period_end ? '0 : cnt + 1'b1;
            if (tck_rise)
                tck <= 1'b1;
            else if (period_end)
                tck <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator: one IR load plus one full DR scan
// per command, capturing tdo and ir_out into a held response.
module cpu_debug_scan_master
    import cpu_debug_scan_pkg::*;
#(
    parameter int SR_WIDTH = DEF_SR_WIDTH,
    parameter int IR_WIDTH = DEF_IR_WIDTH,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir,
    output logic                busy,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                jtag_state_rti,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr
);

    localparam int BW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(SR_WIDTH - 1);

    scan_state_t         state;
    logic [BW-1:0]       bit_cnt;
    logic [SR_WIDTH-1:0] shift_q;
    logic                scan_en;
    logic                tck_rise;
    logic                period_end;

    assign scan_en = (state == ST_UIR) | (state == ST_CDR) |
                     (state == ST_SDR) | (state == ST_UDR);

    assign busy           = ~cmd_ready;
    assign jtag_state_rti = cmd_ready;

    cpu_debug_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) u_tck_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (scan_en),
        .tck       (tck),
        .tck_rise  (tck_rise),
        .period_end(period_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_dr    <= '0;
            rsp_ir    <= '0;
            ir_in     <= '0;
            tdi       <= 1'b0;
            vs_uir    <= 1'b0;
            vs_cdr    <= 1'b0;
            vs_sdr    <= 1'b0;
            vs_udr    <= 1'b0;
            bit_cnt   <= '0;
            shift_q   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state     <= ST_UIR;
                        cmd_ready <= 1'b0;
                        vs_uir    <= 1'b1;
                        ir_in     <= cmd_ir;
                        shift_q   <= cmd_dr;
                        rsp_dr    <= '0;
                    end
                end
                ST_UIR: begin
                    if (period_end) begin
                        state  <= ST_CDR;
                        vs_uir <= 1'b0;
                        vs_cdr <= 1'b1;
                    end
                end
                ST_CDR: begin
                    if (period_end) begin
                        state   <= ST_SDR;
                        vs_cdr  <= 1'b0;
                        vs_sdr  <= 1'b1;
                        bit_cnt <= '0;
                        tdi     <= shift_q[0];
                    end
                end
                ST_SDR: begin
                    if (tck_rise)
                        rsp_dr[bit_cnt] <= tdo;
                    if (period_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            state  <= ST_UDR;
                            vs_sdr <= 1'b0;
                            vs_udr <= 1'b1;
                            tdi    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tdi     <= shift_q[1];
                        end
                    end
                end
                ST_UDR: begin
                    if (tck_rise)
                        rsp_ir <= ir_out;
                    if (period_end) begin
                        state     <= ST_RSP;
                        vs_udr    <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Bench for cpu_debug_scan_master: loopback slave model, cycle-exact
// strobe timing, stall, abort by reset, and a TCK_DIV=1 instance.
module tb_cpu_debug_scan_master;
    import cpu_debug_scan_pkg::*;

    localparam int SW  = 38;
    localparam int TD  = 2;
    localparam int P   = 2 * TD;
    localparam int LAT = 1 + (SW + 3) * P;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [1:0]    cmd_ir = '0;
    logic [SW-1:0] cmd_dr = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [SW-1:0] rsp_dr;
    logic [1:0]    rsp_ir, ir_in, ir_out = '0;
    logic          busy, tck, tdi, tdo, jtag_state_rti;
    logic          vs_uir, vs_cdr, vs_sdr, vs_udr;

    logic          cmd_valid1 = 1'b0, cmd_ready1;
    logic [1:0]    cmd_ir1 = '0;
    logic [SW-1:0] cmd_dr1 = '0;
    logic          rsp_valid1, rsp_ready1 = 1'b0;
    logic [SW-1:0] rsp_dr1;
    logic [1:0]    rsp_ir1, ir_in1, ir_out1 = 2'b01;
    logic          busy1, tck1, tdi1, tdo1, rti1;
    logic          vs_uir1, vs_cdr1, vs_sdr1, vs_udr1;

    // Debug-slave stand-in: tdo is bit 0, shifts tdi in at each SDR tck rise.
    logic [SW-1:0] slave_sr = '0;
    always @(posedge tck)
        if (vs_sdr) slave_sr <= {tdi, slave_sr[SW-1:1]};
    assign tdo  = slave_sr[0];
    assign tdo1 = 1'b1;

    cpu_debug_scan_master #(.SR_WIDTH(SW), .IR_WIDTH(2), .TCK_DIV(TD)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dr(rsp_dr), .rsp_ir(rsp_ir), .busy(busy),
        .tck(tck), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out),
        .jtag_state_rti(jtag_state_rti),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr)
    );

    cpu_debug_scan_master #(.SR_WIDTH(SW), .IR_WIDTH(2), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(cmd_ir1), .cmd_dr(cmd_dr1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_dr(rsp_dr1), .rsp_ir(rsp_ir1), .busy(busy1),
        .tck(tck1), .tdi(tdi1), .tdo(tdo1),
        .ir_in(ir_in1), .ir_out(ir_out1),
        .jtag_state_rti(rti1),
        .vs_uir(vs_uir1), .vs_cdr(vs_cdr1),
        .vs_sdr(vs_sdr1), .vs_udr(vs_udr1)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_scan(input logic [1:0] ir, input logic [SW-1:0] dr,
                            input logic [1:0] iro, input int stall);
        logic [SW-1:0] exp_dr, held;
        logic [9:0]    got_v, exp_v;
        int            bad, bad_ir, rises, per, ph, idx;
        logic          prev_tck, in_sdr;
        bad = 0; bad_ir = 0; rises = 0; prev_tck = 1'b0;
        @(negedge clk);
        check("ready_before", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_ir = ir; cmd_dr = dr; ir_out = iro;
        @(posedge clk);
        exp_dr = slave_sr;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmd_valid = 1'b0; cmd_ir = ~ir; cmd_dr = ~dr;
            end
            per = (c - 1) / P;
            ph  = (c - 1) % P;
            in_sdr = (per >= 2) && (per < SW + 2);
            idx = in_sdr ? per - 2 : 0;
            exp_v = {per == 0, per == 1, in_sdr, per == SW + 2,
                     (c < LAT) && (ph >= TD), in_sdr ? dr[idx] : 1'b0,
                     c == LAT, 1'b0, 1'b1, 1'b0};
            got_v = {vs_uir, vs_cdr, vs_sdr, vs_udr, tck, tdi,
                     rsp_valid, cmd_ready, busy, jtag_state_rti};
            if (got_v !== exp_v) bad++;
            if (ir_in !== ir) bad_ir++;
            if (tck && !prev_tck) rises++;
            prev_tck = tck;
        end
        check("seq", 64'(bad), 64'd0);
        check("tck_rises", 64'(rises), 64'(SW + 3));
        check("ir_in_scan", 64'(bad_ir), 64'd0);
        check("rsp_dr", 64'(rsp_dr), 64'(exp_dr));
        check("rsp_ir", 64'(rsp_ir), 64'(iro));
        check("slave_load", 64'(slave_sr), 64'(dr));
        held = rsp_dr;
        bad = 0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if ({rsp_valid, cmd_ready, tck, busy} !== 4'b1001) bad++;
            if (rsp_dr !== held || rsp_ir !== iro) bad++;
            cmd_valid = (s == stall / 2);
        end
        if (stall > 0) check("stall", 64'(bad), 64'd0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp", 64'({rsp_valid, cmd_ready, jtag_state_rti, busy}),
              64'b0110);
        @(negedge clk);
        check("no_queue", 64'({busy, vs_uir, tck}), 64'd0);
        check("ir_hold", 64'(ir_in), 64'(ir));
    endtask

    task automatic abort_scan();
        int bad;
        logic [63:0] r;
        r = {$urandom, $urandom};
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ir = IR_TRACECTRL; cmd_dr = r[SW-1:0];
        @(posedge clk);
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
        end
        check("busy_at_50", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_strobes",
              64'({vs_uir, vs_cdr, vs_sdr, vs_udr, tck, tdi}), 64'd0);
        check("rst_flags",
              64'({rsp_valid, cmd_ready, busy, jtag_state_rti}), 64'b0101);
        check("rst_ir_in", 64'(ir_in), 64'd0);
        check("rst_rsp", 64'({rsp_ir, rsp_dr}), 64'd0);
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rsp_valid || busy) bad++;
        end
        check("abort_quiet", 64'(bad), 64'd0);
    endtask

    task automatic run_div1();
        int first, bad, rises;
        logic prev;
        logic [63:0] r;
        r = {$urandom, $urandom};
        first = 0; bad = 0; rises = 0; prev = 1'b0;
        @(negedge clk);
        cmd_valid1 = 1'b1; cmd_ir1 = IR_TRACEMEM; cmd_dr1 = r[SW-1:0];
        @(posedge clk);
        for (int c = 1; c <= 300 && first == 0; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid1 = 1'b0;
            if (c <= 82 && tck1 !== 1'((c - 1) % 2)) bad++;
            if ($countones({vs_uir1, vs_cdr1, vs_sdr1, vs_udr1}) > 1) bad++;
            if (tck1 && !prev) rises++;
            prev = tck1;
            if (rsp_valid1) first = c;
        end
        check("d1_latency", 64'(first), 64'd83);
        check("d1_tck", 64'(bad), 64'd0);
        check("d1_rises", 64'(rises), 64'(SW + 3));
        check("d1_rsp_dr", 64'(rsp_dr1), 64'({SW{1'b1}}));
        check("d1_rsp_ir", 64'(rsp_ir1), 64'(ir_out1));
        rsp_ready1 = 1'b1;
        @(negedge clk);
        rsp_ready1 = 1'b0;
        check("d1_idle", 64'({cmd_ready1, busy1, rti1, tdi1}), 64'b1010);
        check("d1_ir_in", 64'(ir_in1), 64'(IR_TRACEMEM));
    endtask

    initial begin
        logic [63:0] r;
        repeat (3) @(negedge clk);
        check("reset_main",
              64'({tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, rsp_valid,
                   busy, cmd_ready, jtag_state_rti}), 64'b0000000011);
        check("reset_vals", 64'({ir_in, rsp_ir, rsp_dr}), 64'd0);
        check("reset_d1", 64'({tck1, rsp_valid1, busy1, cmd_ready1, rti1}),
              64'b00011);
        reset = 1'b0;

        run_scan(IR_BREAK, 38'h2A_5A5A_5A5A, 2'b11, 0);
        check("loop_first", 64'(rsp_dr), 64'd0);
        run_scan(IR_BREAK, 38'h2A_5A5A_5A5A, 2'b11, 20);
        check("loop_second", 64'(rsp_dr), 64'h2A_5A5A_5A5A);

        abort_scan();

        for (int k = 0; k < 4; k++) begin
            r = {$urandom, $urandom};
            run_scan(2'($urandom_range(0, 3)), r[SW-1:0],
                     2'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
        end

        run_div1();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
